// File: rtl/dk_chinh_gpg.sv
// dk_chinh_gpg: mode/edit controller for the hour-minute-second clock.
// Cycles RUN -> SET_S -> SET_M -> SET_H on the mode pulse, turns the
// debounced up/down levels into single and auto-repeat inc/dec pulses,
// blinks the field being edited and pauses the time counters while editing.
//
// Pulse contract: inc and dec are registered one-cycle strobes, never both
// high. There is no back-pressure: the consumer acts on every strobe. No
// strobe is issued in the cycle gt_mod changes, and none is issued in RUN.
module dk_chinh_gpg #(
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int TIMEOUT_S = 10
) (
    input  logic       ckht,
    input  logic       rst,
    input  logic       btn_mod,
    input  logic       cdb_up,
    input  logic       cdb_dw,
    input  logic       ena_ms,
    input  logic       ena1hz,
    input  logic       ena2hz,
    output logic [1:0] gt_mod,
    output logic       inc,
    output logic       dec,
    output logic [2:0] ena_field,
    output logic       run_ena
);

    localparam int HW = $clog2(HOLD_MS + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    // The hold counter fires when an ena_ms tick would carry it to HOLD_MS;
    // reloading with HOLD_MS-REPEAT_MS spaces later pulses REPEAT_MS apart.
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_MS - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_MS - REPEAT_MS);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_MS);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_S - 1);
    localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_S);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_S = 2'd1,
        MODE_SET_M = 2'd2,
        MODE_SET_H = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        K_IDLE  = 2'd0,
        K_PRESS = 2'd1,
        K_HOLD  = 2'd2,
        K_LOCK  = 2'd3
    } key_t;

    mode_t           mode_q, mode_d;
    key_t            key_q, key_d;
    logic            sel_q, sel_d;       // held key: 0 = up, 1 = down
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [TW-1:0]   to_q, to_d;
    logic            up_q, dw_q;
    logic [1:0]      mode_inc;
    logic            up_rise, dw_rise;
    logic            to_clr, to_fire, mode_chg, pulse_ok;
    logic            held_lvl, other_lvl;
    logic            fire;
    logic            inc_d, dec_d, run_d, blink;
    logic [2:0]      field_d;

    assign up_rise   = cdb_up & ~up_q;
    assign dw_rise   = cdb_dw & ~dw_q;
    assign to_clr    = btn_mod | cdb_up | cdb_dw | up_rise | dw_rise;
    assign held_lvl  = sel_q ? cdb_dw : cdb_up;
    assign other_lvl = sel_q ? cdb_up : cdb_dw;
    assign mode_inc  = mode_q + 2'd1;
    assign gt_mod    = mode_q;

    // Mode sequencing and inactivity timeout; a mode pulse beats the timeout.
    always_comb begin
        mode_d  = mode_q;
        to_d    = to_q;
        to_fire = (mode_q != MODE_RUN) & ena1hz & ~to_clr & (to_q >= TO_LAST);
        if (btn_mod) begin
            mode_d = mode_t'(mode_inc);
        end else if (to_fire) begin
            mode_d = MODE_RUN;
        end
        if (mode_d == MODE_RUN || to_clr) begin
            to_d = '0;
        end else if (ena1hz && to_q != TO_MAX) begin
            to_d = to_q + 1'b1;
        end
        mode_chg = btn_mod | to_fire;
        pulse_ok = (mode_q != MODE_RUN) & ~mode_chg;
    end

    // Key FSM: press pulse, hold-to-repeat, and lock-out on conflicts.
    always_comb begin
        key_d  = key_q;
        sel_d  = sel_q;
        hcnt_d = hcnt_q;
        fire   = 1'b0;
        unique case (key_q)
            K_IDLE: begin
                if (up_rise | dw_rise) begin
                    if (mode_chg || (cdb_up && cdb_dw)) begin
                        key_d = K_LOCK;
                    end else begin
                        key_d = K_PRESS;
                        sel_d = dw_rise;
                        fire  = 1'b1;
                    end
                end
            end
            K_PRESS: begin
                if (mode_chg || other_lvl) begin
                    key_d = K_LOCK;
                end else if (!held_lvl) begin
                    key_d = K_IDLE;
                end else begin
                    key_d  = K_HOLD;
                    hcnt_d = '0;
                end
            end
            K_HOLD: begin
                if (mode_chg || other_lvl) begin
                    key_d = K_LOCK;
                end else if (!held_lvl) begin
                    key_d = K_IDLE;
                end else if (ena_ms) begin
                    if (hcnt_q >= HOLD_LAST) begin
                        fire   = 1'b1;
                        hcnt_d = HOLD_RELOAD;
                    end else if (hcnt_q != HOLD_MAX) begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            K_LOCK: begin
                if (!cdb_up && !cdb_dw) begin
                    key_d = K_IDLE;
                end
            end
            default: key_d = K_IDLE;
        endcase
    end

    // Next values of the registered outputs, aligned with the next gt_mod.
    always_comb begin
        inc_d   = fire & pulse_ok & ~sel_d;
        dec_d   = fire & pulse_ok & sel_d;
        run_d   = (mode_d == MODE_RUN);
        blink   = ena2hz | cdb_up | cdb_dw;
        field_d = 3'b111;
        unique case (mode_d)
            MODE_SET_S: field_d = {2'b11, blink};
            MODE_SET_M: field_d = {1'b1, blink, 1'b1};
            MODE_SET_H: field_d = {blink, 2'b11};
            default:    field_d = 3'b111;
        endcase
    end

    // State registers: mode, key FSM, counters and key level history.
    always_ff @(posedge ckht) begin
        if (!rst) begin
            mode_q <= MODE_RUN;
            key_q  <= K_IDLE;
            sel_q  <= 1'b0;
            hcnt_q <= '0;
            to_q   <= '0;
            up_q   <= 1'b0;
            dw_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            key_q  <= key_d;
            sel_q  <= sel_d;
            hcnt_q <= hcnt_d;
            to_q   <= to_d;
            up_q   <= cdb_up;
            dw_q   <= cdb_dw;
        end
    end

    // Registered outputs.
    always_ff @(posedge ckht) begin
        if (!rst) begin
            inc       <= 1'b0;
            dec       <= 1'b0;
            ena_field <= 3'b111;
            run_ena   <= 1'b1;
        end else begin
            inc       <= inc_d;
            dec       <= dec_d;
            ena_field <= field_d;
            run_ena   <= run_d;
        end
    end

endmodule

// File: doc/dk_chinh_gpg.md
Name: dk_chinh_gpg

Overview:
Mode/edit controller for the hour-minute-second clock. Sequences the run/set-second/set-minute/set-hour modes from the mode button and turns debounced up/down levels into single and auto-repeat inc/dec pulses for the selected field. Drives the per-field blink enables and pauses the time counters while editing. Sits between the debounce stage and the HMS counter/display datapath, replacing free-running mode counting with a timed, lock-safe FSM.

Parameters:
HOLD_MS, 500, ena_ms ticks a single button must be held before auto-repeat starts
REPEAT_MS, 100, ena_ms ticks between auto-repeat pulses (1 ≤ REPEAT_MS ≤ HOLD_MS)
TIMEOUT_S, 10, ena1hz ticks without button activity before an edit mode falls back to RUN

Ports:
ckht  in  1  system clock
rst  in  1  synchronous reset, active-low
btn_mod  in  1  debounced one-cycle mode pulse
cdb_up  in  1  debounced up-button level
cdb_dw  in  1  debounced down-button level
ena_ms  in  1  1 kHz one-cycle enable
ena1hz  in  1  1 Hz one-cycle enable
ena2hz  in  1  2 Hz square-wave level used for blinking
gt_mod  out  2  mode: 0 RUN, 1 SET_S, 2 SET_M, 3 SET_H
inc  out  1  one-cycle increment pulse for the selected field
dec  out  1  one-cycle decrement pulse for the selected field
ena_field  out  3  display enable per field {hour, min, sec}, 1 = lit
run_ena  out  1  1 = time counters may advance

Behaviour:
- Interface: one clock ckht; rst synchronous, active-low; all outputs registered.
- Reset (rst=0 at a ckht edge): gt_mod=0, inc=0, dec=0, ena_field=3'b111, run_ena=1; all counters cleared; key FSM in IDLE. Reset mid-hold or mid-edit aborts with no pulse.
- Mode FSM: on btn_mod, RUN→SET_S→SET_M→SET_H→RUN; gt_mod updates the cycle after the pulse.
- Timeout: the counter clears on any btn_mod, cdb_up/cdb_dw rising edge, or while any key is held. In SET_x it increments on ena1hz. When it reaches TIMEOUT_S, gt_mod→0 next cycle. It is held at 0 in RUN.
- run_ena = (gt_mod==0).
- ena_field: RUN → 111. SET_x → the selected bit = ena2hz, or solid 1 while cdb_up or cdb_dw is held; the other bits = 1.
- Key FSM states:
  - IDLE: no key held. Exactly one key rising → PRESS; the edge is detected on a registered copy of the level.
  - PRESS: emits one pulse. inc or dec is high exactly 1 cycle, in the cycle after the first sampled 1. Hold counter ← 0 → HOLD.
  - HOLD: the hold counter increments on ena_ms. On reaching HOLD_MS, emit one pulse and set the counter ← HOLD_MS−REPEAT_MS, so subsequent pulses come every REPEAT_MS ticks.
  - LOCK: no pulses; exit to IDLE only when both keys are 0.
- Key FSM exits:
  - Release of the held key → IDLE.
  - Other key also pressed → LOCK.
  - Mode change or timeout → LOCK.
- Key FSM rules:
  - Both keys rising in the same cycle → LOCK, no pulse.
  - In RUN, the key FSM still tracks state but inc/dec are forced 0.
  - btn_mod in the same cycle as a key edge: the mode change wins, no pulse, key FSM → LOCK.
- inc and dec are never both 1; no pulse is ever emitted in the cycle gt_mod changes.
- Counter widths: $clog2(HOLD_MS+1) and $clog2(TIMEOUT_S+1). Counters saturate and never wrap.

Test Plan:
(Sim params HOLD_MS=5, REPEAT_MS=2, TIMEOUT_S=3; ena_ms every 4 cycles; ena1hz every 20 cycles.)
- Reset then btn_mod ×4 → gt_mod 1,2,3,0, each one cycle after its pulse; run_ena 0 in modes 1–3; ena_field=111 in mode 0.
- gt_mod=2, cdb_up 0→1 for 3 cycles → single inc 1 cycle after the rise; dec=0; ena_field[1] solid 1 while held, then follows ena2hz.
- gt_mod=1, hold cdb_dw for 40 cycles → dec at press, again after 5 ena_ms ticks, then every 2 ticks (4 dec total).
- gt_mod=3, holding up, press dw → no further pulses after the dw rise; release both → IDLE; the next up press gives 1 inc.
- gt_mod=1, idle 3 ena1hz ticks → gt_mod=0; a key press in the 3rd-tick cycle resets the count and keeps the mode.
- gt_mod=0, hold cdb_up → inc/dec stay 0. btn_mod coincident with an up edge → mode 1, no inc until release and re-press. rst=0 mid-repeat → all outputs at reset values next cycle.
